gray_box3x3: RTL and testbench



---
 rtl/gray_pkg.sv | 24 ++
 rtl/gray_line_buf.sv | 26 ++
 rtl/gray_box3x3.sv | 130 +++++++++++++
 tb/tb_gray_box3x3.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared constants and divide-by-9 helpers for the gray_box3x3 mean filter.
package gray_pkg;

    localparam int PIX_W_DEF  = 8;
    localparam int DATA_W_DEF = 32;
    localparam int WIDTH_DEF  = 500;
    localparam int HEIGHT_DEF = 500;

    // Nine PIX_W values (plus the rounding offset of 4) always fit in PIX_W+4 bits.
    function automatic int sum_w(input int pix_w);
        return pix_w + 4;
    endfunction

    // For every x < 2**w: x/9 == (x*mul) >> shift, where shift = w+3 and mul = ceil(2**shift/9).
    // The excess 9*mul - 2**shift is at most 8, so the added error x*8/(9*2**shift) stays below 1/9.
    function automatic int div9_shift(input int w);
        return w + 3;
    endfunction

    function automatic int div9_mul(input int w);
        return ((1 << (w + 3)) + 8) / 9;
    endfunction

endpackage

// File: rtl/gray_line_buf.sv
// Single-port line memory with asynchronous read, so a read and a write at the same address return the old word.
module gray_line_buf
    import gray_pkg::*;
#(
    parameter int DEPTH = WIDTH_DEF,
    parameter int PIX_W = PIX_W_DEF,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             en,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/gray_box3x3.sv
// Streaming 3x3 floor-mean filter over a WIDTH x HEIGHT raster; emits interior pixels only.
// Define GRAY_BOX3X3_ROUND_EN to round to nearest instead of flooring.
module gray_box3x3
    import gray_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PIX_W  = PIX_W_DEF,
    parameter int WIDTH  = WIDTH_DEF,
    parameter int HEIGHT = HEIGHT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int SUM_W     = sum_w(PIX_W);
    localparam int DIV_SHIFT = div9_shift(SUM_W);
    localparam int DIV_MUL   = div9_mul(SUM_W);
    localparam int PROD_W    = SUM_W + DIV_SHIFT;
    localparam int CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW        = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic [CW-1:0]              col;
    logic [RW-1:0]              row;
    logic [PIX_W-1:0]           pixel;
    logic [PIX_W-1:0]           lb0_q;
    logic [PIX_W-1:0]           lb1_q;
    logic [2:0][2:0][PIX_W-1:0] win;
    logic [2:0][2:0][PIX_W-1:0] win_next;
    logic [SUM_W-1:0]           sum_next;
    logic [SUM_W-1:0]           sum_r;
    logic                       s1_valid;
    logic                       s1_last;
    logic                       stall;
    logic                       accept;
    logic                       emit;
    logic                       at_last;
    logic [PROD_W-1:0]          prod;
    logic                       unused_in;

    assign pixel     = in_data[PIX_W-1:0];
    assign unused_in = ^in_data[DATA_W-1:PIX_W];
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign accept    = in_valid & in_ready;
    assign emit      = (row >= RW'(2)) && (col >= CW'(2));
    assign at_last   = (row == RW'(HEIGHT - 1)) && (col == CW'(WIDTH - 1));

    // lb0 holds row-2 and lb1 holds row-1; each accept pushes the column down one line.
    gray_line_buf #(.DEPTH(WIDTH), .PIX_W(PIX_W), .AW(CW)) u_lb0 (
        .clk   (clk),
        .en    (accept),
        .addr  (col),
        .wdata (lb1_q),
        .rdata (lb0_q)
    );

    gray_line_buf #(.DEPTH(WIDTH), .PIX_W(PIX_W), .AW(CW)) u_lb1 (
        .clk   (clk),
        .en    (accept),
        .addr  (col),
        .wdata (pixel),
        .rdata (lb1_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == CW'(WIDTH - 1)) begin
                col <= '0;
                row <= (row == RW'(HEIGHT - 1)) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // The sum is taken over the window as it will look after this accept.
    always_comb begin
        win_next    = win;
        win_next[0] = win[1];
        win_next[1] = win[2];
        win_next[2] = {lb0_q, lb1_q, pixel};
        sum_next    = '0;
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 3; r++) begin
                sum_next = sum_next + SUM_W'(win_next[c][r]);
            end
        end
`ifdef GRAY_BOX3X3_ROUND_EN
        sum_next = sum_next + SUM_W'(4);
`endif
    end

    assign prod = PROD_W'(sum_r) * PROD_W'(DIV_MUL);

    // Every stage holds while the output is stalled, keeping out_data/out_last stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win       <= '0;
            sum_r     <= '0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (!stall) begin
            if (accept) begin
                win   <= win_next;
                sum_r <= sum_next;
            end
            s1_valid  <= accept & emit;
            s1_last   <= accept & at_last;
            out_valid <= s1_valid;
            out_last  <= s1_valid & s1_last;
            if (s1_valid) begin
                out_data <= DATA_W'(prod >> DIV_SHIFT);
            end
        end
    end

endmodule

// File: tb/tb_gray_box3x3.sv
// Directed self-checking bench for gray_box3x3 on a 5x4 frame.
module tb_gray_box3x3;

    localparam int DATA_W = 32;
    localparam int PIX_W  = 8;
    localparam int WIDTH  = 5;
    localparam int HEIGHT = 4;
    localparam int NOUT   = (WIDTH - 2) * (HEIGHT - 2);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    int checks = 0;
    int errors = 0;
    int pix[$];
    int exp_q[$];
    int got_q[$];
    bit got_last_q[$];
    bit bp_mode = 1'b0;
    bit lat_track = 1'b0;
    int cyc = 0;
    int acc_cyc = -1;
    int first_valid_cyc = -1;
    bit prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    logic prev_last = 1'b0;

    gray_box3x3 #(
        .DATA_W (DATA_W),
        .PIX_W  (PIX_W),
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Handshake invariants and output capture, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("in_ready", in_ready, !(out_valid && !out_ready));
            if (prev_stall) begin
                checkOutput("hold_valid", out_valid, 1);
                checkOutput("hold_data", out_data, prev_data);
                checkOutput("hold_last", out_last, prev_last);
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready) begin
                got_q.push_back(int'(out_data));
                got_last_q.push_back(out_last);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic clearQueues();
        pix.delete();
        exp_q.delete();
        got_q.delete();
        got_last_q.delete();
    endtask

    task automatic buildConst(input int v);
        for (int k = 0; k < WIDTH * HEIGHT; k++) pix.push_back(v);
    endtask

    task automatic buildRamp();
        for (int r = 0; r < HEIGHT; r++)
            for (int c = 0; c < WIDTH; c++) pix.push_back(r * WIDTH + c);
    endtask

    task automatic buildCorner(input int corner, input int rest);
        pix.push_back(corner);
        for (int k = 1; k < WIDTH * HEIGHT; k++) pix.push_back(rest);
    endtask

    task automatic applyStimulus(input bit do_drain);
        int i;
        int guard;
        logic [PIX_W-1:0] p;
        i = 0;
        guard = 0;
        while (i < pix.size() && guard < 2000) begin
            p         = PIX_W'(pix[i]);
            in_valid  = 1'b1;
            in_data   = {24'hA5C35A, p};
            out_ready = bp_mode ? ($urandom_range(0, 99) >= 30) : 1'b1;
            @(negedge clk);
            if (in_ready) begin
                if (lat_track && i == 2 * WIDTH + 2) acc_cyc = cyc;
                i++;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput("feed_done", i, pix.size());
        in_valid = 1'b0;
        if (do_drain) begin
            for (int k = 0; k < 40; k++) begin
                out_ready = (bp_mode && k < 30) ? ($urandom_range(0, 99) >= 30) : 1'b1;
                @(posedge clk);
                #1;
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic checkResults(input string tag);
        checkOutput({tag, "_count"}, got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checkOutput($sformatf("%s_data%0d", tag, k), got_q[k], exp_q[k]);
            checkOutput($sformatf("%s_last%0d", tag, k), got_last_q[k], (k % NOUT) == NOUT - 1);
        end
    endtask

    initial begin
        int ramp_exp[6];
        int round_first;
        ramp_exp = '{6, 7, 8, 11, 12, 13};
`ifdef GRAY_BOX3X3_ROUND_EN
        round_first = 2;
`else
        round_first = 1;
`endif

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        clearQueues();
        buildConst(100);
        repeat (NOUT) exp_q.push_back(100);
        lat_track = 1'b1;
        first_valid_cyc = -1;
        applyStimulus(1'b1);
        lat_track = 1'b0;
        checkResults("const");
        checkOutput("latency", first_valid_cyc - acc_cyc, 2);

        clearQueues();
        buildRamp();
        foreach (ramp_exp[k]) exp_q.push_back(ramp_exp[k]);
        applyStimulus(1'b1);
        checkResults("ramp");

        clearQueues();
        buildConst(255);
        repeat (NOUT) exp_q.push_back(255);
        applyStimulus(1'b1);
        checkResults("sat");

        clearQueues();
        buildRamp();
        buildRamp();
        repeat (2) foreach (ramp_exp[k]) exp_q.push_back(ramp_exp[k]);
        bp_mode = 1'b1;
        applyStimulus(1'b1);
        bp_mode = 1'b0;
        checkResults("bp");

        clearQueues();
        repeat (7) pix.push_back(200);
        applyStimulus(1'b0);
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("midrst_out_valid", out_valid, 0);
        end
        checkOutput("midrst_no_output", got_q.size(), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clearQueues();
        buildConst(50);
        repeat (NOUT) exp_q.push_back(50);
        applyStimulus(1'b1);
        checkResults("midrst");

        clearQueues();
        buildCorner(1, 2);
        exp_q.push_back(round_first);
        repeat (NOUT - 1) exp_q.push_back(2);
        applyStimulus(1'b1);
        checkResults("sum17");

        clearQueues();
        buildCorner(5, 1);
        repeat (NOUT) exp_q.push_back(1);
        applyStimulus(1'b1);
        checkResults("sum13");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

endmodule
